// File: rtl/phase_seq_pkg.sv
// rtl/phase_seq_pkg.sv - shared state encoding, lamp aspects and width helper for the phase sequencer
package phase_seq_pkg;

    typedef enum logic [2:0] {
        ST_INIT       = 3'd0,
        ST_GREEN_BASE = 3'd1,
        ST_GREEN_EXT  = 3'd2,
        ST_YELLOW     = 3'd3,
        ST_ALL_RED    = 3'd4,
        ST_WALK       = 3'd5,
        ST_FLASH      = 3'd6
    } state_t;

    // Per-phase lamp aspect packed as {red, yellow, green}
    localparam logic [2:0] LAMP_RED  = 3'b100;
    localparam logic [2:0] LAMP_YEL  = 3'b010;
    localparam logic [2:0] LAMP_GRN  = 3'b001;
    localparam logic [2:0] LAMP_DARK = 3'b000;

    function automatic int clog2_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/phase_sequencer_fsm_interval_timer.sv
// rtl/phase_sequencer_fsm_interval_timer.sv - loadable tick-driven down counter that flags interval end
module interval_timer #(
    parameter int            TW      = 8,
    parameter logic [TW-1:0] RST_VAL = '0
) (
    input  logic          clk,
    input  logic          Reset_n,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    input  logic          Tick,
    output logic          expire
);

    logic [TW-1:0] cnt;

    // Load wins over decrement, so a tick in the load cycle never shortens the new interval
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt <= RST_VAL;
        end else if (load) begin
            cnt <= load_val;
        end else if (Tick && (cnt != '0)) begin
            cnt <= cnt - TW'(1);
        end
    end

    assign expire = Tick && (cnt == '0);

endmodule

// File: rtl/phase_sequencer_fsm.sv
// rtl/phase_sequencer_fsm.sv - N-phase signal controller with walk interval and flashing-yellow mode
module phase_sequencer_fsm
    import phase_seq_pkg::*;
#(
    parameter int NUM_PHASES = 2,
    parameter int TW         = 8,
    parameter int T_BASE     = 6,
    parameter int T_EXT      = 3,
    parameter int T_YEL      = 2,
    parameter int T_CLR      = 1,
    parameter int T_WALK     = 3,
    parameter int WALK_PHASE = 0
) (
    input  logic                           clk,
    input  logic                           Reset_n,
    input  logic                           Tick,
    input  logic [NUM_PHASES-1:0]          Sensor,
    input  logic                           Walk_Req,
    input  logic                           Reprogram,
    input  logic                           Flash_Mode,
    output logic [NUM_PHASES-1:0]          Red,
    output logic [NUM_PHASES-1:0]          Yellow,
    output logic [NUM_PHASES-1:0]          Green,
    output logic                           Walk,
    output logic                           WalkReg_Reset,
    output logic [clog2_w(NUM_PHASES)-1:0] Phase
);

    localparam int PW = clog2_w(NUM_PHASES);

    state_t                state, next_state;
    logic [PW-1:0]         next_phase, phase_inc;
    logic                  walk_pending, pending_next;
    logic                  flash_q, flash_next;
    logic                  expire, load, enter_walk;
    logic [TW-1:0]         load_val;
    logic [2:0]            aspect;
    logic [NUM_PHASES-1:0] red_n, yel_n, grn_n;

    interval_timer #(
        .TW      (TW),
        .RST_VAL (TW'(T_CLR - 1))
    ) u_timer (
        .clk      (clk),
        .Reset_n  (Reset_n),
        .load     (load),
        .load_val (load_val),
        .Tick     (Tick),
        .expire   (expire)
    );

    assign phase_inc = (Phase == PW'(NUM_PHASES - 1)) ? '0 : Phase + PW'(1);

    always_comb begin
        next_state = state;
        next_phase = Phase;
        if (Reprogram) begin
            next_state = ST_INIT;
            next_phase = '0;
        end else if (Flash_Mode) begin
            next_state = ST_FLASH;
        end else begin
            case (state)
                ST_INIT: if (expire) begin
                    next_state = ST_GREEN_BASE;
                    next_phase = '0;
                end
                ST_GREEN_BASE: if (expire) next_state = Sensor[Phase] ? ST_GREEN_EXT : ST_YELLOW;
                ST_GREEN_EXT:  if (expire) next_state = ST_YELLOW;
                ST_YELLOW:     if (expire) next_state = ST_ALL_RED;
                ST_ALL_RED: if (expire) begin
                    if ((Phase == PW'(WALK_PHASE)) && walk_pending) begin
                        next_state = ST_WALK;
                    end else begin
                        next_state = ST_GREEN_BASE;
                        next_phase = phase_inc;
                    end
                end
                ST_WALK: if (expire) begin
                    next_state = ST_GREEN_BASE;
                    next_phase = phase_inc;
                end
                ST_FLASH: begin
                    next_state = ST_INIT;
                    next_phase = '0;
                end
                default: begin
                    next_state = ST_INIT;
                    next_phase = '0;
                end
            endcase
        end
    end

    assign load       = (next_state != state) || Reprogram;
    assign enter_walk = (next_state == ST_WALK) && (state != ST_WALK);

    always_comb begin
        case (next_state)
            ST_GREEN_BASE: load_val = TW'(T_BASE - 1);
            ST_GREEN_EXT:  load_val = TW'(T_EXT - 1);
            ST_YELLOW:     load_val = TW'(T_YEL - 1);
            ST_WALK:       load_val = TW'(T_WALK - 1);
            ST_FLASH:      load_val = '0;
            default:       load_val = TW'(T_CLR - 1);
        endcase
    end

    // The request held during the WalkReg_Reset cycle is the one just served
    always_comb begin
        pending_next = walk_pending;
        if (Reprogram || enter_walk) begin
            pending_next = 1'b0;
        end else if (Walk_Req && !WalkReg_Reset) begin
            pending_next = 1'b1;
        end
    end

    always_comb begin
        if (next_state != ST_FLASH) begin
            flash_next = 1'b0;
        end else if (state != ST_FLASH) begin
            flash_next = 1'b1;
        end else begin
            flash_next = flash_q ^ Tick;
        end
    end

    always_comb begin
        case (next_state)
            ST_GREEN_BASE, ST_GREEN_EXT: aspect = LAMP_GRN;
            ST_YELLOW:                   aspect = LAMP_YEL;
            ST_FLASH:                    aspect = flash_next ? LAMP_YEL : LAMP_DARK;
            default:                     aspect = LAMP_RED;
        endcase
        red_n = '0;
        yel_n = '0;
        grn_n = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            if ((next_state == ST_FLASH) || (i == int'(next_phase))) begin
                {red_n[i], yel_n[i], grn_n[i]} = aspect;
            end else begin
                {red_n[i], yel_n[i], grn_n[i]} = LAMP_RED;
            end
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state         <= ST_INIT;
            walk_pending  <= 1'b0;
            flash_q       <= 1'b0;
            Red           <= '1;
            Yellow        <= '0;
            Green         <= '0;
            Walk          <= 1'b0;
            WalkReg_Reset <= 1'b0;
            Phase         <= '0;
        end else begin
            state         <= next_state;
            walk_pending  <= pending_next;
            flash_q       <= flash_next;
            Red           <= red_n;
            Yellow        <= yel_n;
            Green         <= grn_n;
            Walk          <= (next_state == ST_WALK);
            WalkReg_Reset <= enter_walk;
            Phase         <= next_phase;
        end
    end

endmodule

// File: tb/tb_phase_sequencer_fsm.sv
// tb/tb_phase_sequencer_fsm.sv - directed table, corner sequences and model-checked random run
module tb_phase_sequencer_fsm;

    localparam int L_BASE = 6, L_EXT = 3, L_YEL = 2, L_CLR = 1, L_WALK = 3;

    logic       clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       Tick = 1'b1;
    logic [1:0] Sensor = '0;
    logic       Walk_Req = 1'b0;
    logic       Reprogram = 1'b0;
    logic       Flash_Mode = 1'b0;
    logic [1:0] Red, Yellow, Green;
    logic       Walk, WalkReg_Reset;
    logic [0:0] Phase;

    int total = 0;
    int passed = 0;

    phase_sequencer_fsm dut (
        .clk           (clk),
        .Reset_n       (Reset_n),
        .Tick          (Tick),
        .Sensor        (Sensor),
        .Walk_Req      (Walk_Req),
        .Reprogram     (Reprogram),
        .Flash_Mode    (Flash_Mode),
        .Red           (Red),
        .Yellow        (Yellow),
        .Green         (Green),
        .Walk          (Walk),
        .WalkReg_Reset (WalkReg_Reset),
        .Phase         (Phase)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    function automatic logic [8:0] outs();
        return {Red, Yellow, Green, Walk, WalkReg_Reset, Phase};
    endfunction

    // Directed segments: inputs held and outputs required for n consecutive cycles
    typedef struct {
        logic [1:0] sensor;
        logic       wr;
        logic       fm;
        int         n;
        logic [8:0] exp;
    } seg_t;
    seg_t segs[$];

    function automatic seg_t mk(input logic [1:0] s, input logic w, input logic f, input int n,
                                input logic [1:0] r, input logic [1:0] y, input logic [1:0] g,
                                input logic wk, input logic wrr, input logic ph);
        seg_t t;
        t.sensor = s; t.wr = w; t.fm = f; t.n = n;
        t.exp = {r, y, g, wk, wrr, ph};
        return t;
    endfunction

    // Reference model: interval kind plus ticks elapsed inside it
    localparam int K_INIT = 0, K_GRN = 1, K_EXT = 2, K_YEL = 3, K_RED = 4, K_WALK = 5, K_FLASH = 6;
    int m_kind, m_phase, m_el;
    bit m_pend, m_flash, m_wrr;

    function automatic int len_of(input int k);
        case (k)
            K_GRN:   return L_BASE;
            K_EXT:   return L_EXT;
            K_YEL:   return L_YEL;
            K_WALK:  return L_WALK;
            default: return L_CLR;
        endcase
    endfunction

    task automatic model_reset();
        m_kind = K_INIT; m_phase = 0; m_el = 0;
        m_pend = 0; m_flash = 0; m_wrr = 0;
    endtask

    function automatic logic [8:0] model_out();
        logic [1:0] r, y, g;
        r = '0; y = '0; g = '0;
        for (int p = 0; p < 2; p++) begin
            if (m_kind == K_FLASH) y[p] = m_flash;
            else if (p == m_phase && (m_kind == K_GRN || m_kind == K_EXT)) g[p] = 1'b1;
            else if (p == m_phase && m_kind == K_YEL) y[p] = 1'b1;
            else r[p] = 1'b1;
        end
        return {r, y, g, m_kind == K_WALK, m_wrr, 1'(m_phase)};
    endfunction

    task automatic model_step(input bit tk, input logic [1:0] sn, input bit wr, input bit fm, input bit rp);
        bit done, walk_in;
        done = tk && (m_el == len_of(m_kind) - 1);
        walk_in = 0;
        if (rp) begin
            model_reset();
            return;
        end
        if (fm) begin
            if (m_kind != K_FLASH) begin m_kind = K_FLASH; m_flash = 1; end
            else if (tk) m_flash = !m_flash;
        end else if (m_kind == K_FLASH) begin
            m_kind = K_INIT; m_phase = 0; m_el = 0;
        end else if (done) begin
            m_el = 0;
            case (m_kind)
                K_INIT: begin m_kind = K_GRN; m_phase = 0; end
                K_GRN:  m_kind = sn[m_phase] ? K_EXT : K_YEL;
                K_EXT:  m_kind = K_YEL;
                K_YEL:  m_kind = K_RED;
                K_RED: begin
                    if (m_phase == 0 && m_pend) begin m_kind = K_WALK; walk_in = 1; end
                    else begin m_kind = K_GRN; m_phase = (m_phase + 1) % 2; end
                end
                default: begin m_kind = K_GRN; m_phase = (m_phase + 1) % 2; end
            endcase
        end else if (tk) begin
            m_el++;
        end
        if (walk_in) m_pend = 0;
        else if (wr && !m_wrr) m_pend = 1;
        m_wrr = walk_in;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // sel: 0 Walk lit, 1 Green[1] lit, 2 Yellow[1] lit
    task automatic wait_for(input int sel, input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 80 && !ok; i++) begin
            if ((sel == 0 && Walk) || (sel == 1 && Green == 2'b10) || (sel == 2 && Yellow == 2'b10)) ok = 1;
            else step();
        end
        check(name, ok, 1);
    endtask

    task automatic count_wrr(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            if (WalkReg_Reset) n++;
            step();
        end
    endtask

    initial begin
        int n;
        logic [8:0] exp;

        segs.push_back(mk(2'b00, 0, 0, 1,      2'b11, 2'b00, 2'b00, 0, 0, 0));
        segs.push_back(mk(2'b00, 0, 0, L_BASE, 2'b10, 2'b00, 2'b01, 0, 0, 0));
        segs.push_back(mk(2'b00, 0, 0, L_YEL,  2'b10, 2'b01, 2'b00, 0, 0, 0));
        segs.push_back(mk(2'b00, 0, 0, L_CLR,  2'b11, 2'b00, 2'b00, 0, 0, 0));
        segs.push_back(mk(2'b00, 0, 0, 2,      2'b01, 2'b00, 2'b10, 0, 0, 1));
        segs.push_back(mk(2'b00, 1, 0, 1,      2'b01, 2'b00, 2'b10, 0, 0, 1));
        segs.push_back(mk(2'b00, 0, 0, 3,      2'b01, 2'b00, 2'b10, 0, 0, 1));
        segs.push_back(mk(2'b00, 0, 0, L_YEL,  2'b01, 2'b10, 2'b00, 0, 0, 1));
        segs.push_back(mk(2'b00, 0, 0, L_CLR,  2'b11, 2'b00, 2'b00, 0, 0, 1));
        segs.push_back(mk(2'b00, 0, 0, 5,      2'b10, 2'b00, 2'b01, 0, 0, 0));
        segs.push_back(mk(2'b01, 0, 0, 1,      2'b10, 2'b00, 2'b01, 0, 0, 0));
        segs.push_back(mk(2'b01, 0, 0, L_EXT,  2'b10, 2'b00, 2'b01, 0, 0, 0));
        segs.push_back(mk(2'b00, 0, 0, L_YEL,  2'b10, 2'b01, 2'b00, 0, 0, 0));
        segs.push_back(mk(2'b00, 0, 0, L_CLR,  2'b11, 2'b00, 2'b00, 0, 0, 0));
        segs.push_back(mk(2'b00, 0, 0, 1,      2'b11, 2'b00, 2'b00, 1, 1, 0));
        segs.push_back(mk(2'b00, 0, 0, 2,      2'b11, 2'b00, 2'b00, 1, 0, 0));
        segs.push_back(mk(2'b00, 0, 0, L_BASE, 2'b01, 2'b00, 2'b10, 0, 0, 1));
        segs.push_back(mk(2'b00, 0, 0, L_YEL,  2'b01, 2'b10, 2'b00, 0, 0, 1));
        segs.push_back(mk(2'b00, 0, 0, L_CLR,  2'b11, 2'b00, 2'b00, 0, 0, 1));
        segs.push_back(mk(2'b00, 0, 0, L_BASE, 2'b10, 2'b00, 2'b01, 0, 0, 0));
        segs.push_back(mk(2'b01, 0, 0, 1,      2'b10, 2'b01, 2'b00, 0, 0, 0));
        segs.push_back(mk(2'b00, 0, 0, 1,      2'b10, 2'b01, 2'b00, 0, 0, 0));
        segs.push_back(mk(2'b00, 0, 0, L_CLR,  2'b11, 2'b00, 2'b00, 0, 0, 0));
        segs.push_back(mk(2'b00, 0, 0, L_BASE, 2'b01, 2'b00, 2'b10, 0, 0, 1));
        segs.push_back(mk(2'b00, 0, 0, L_YEL,  2'b01, 2'b10, 2'b00, 0, 0, 1));
        segs.push_back(mk(2'b00, 0, 0, L_CLR,  2'b11, 2'b00, 2'b00, 0, 0, 1));
        segs.push_back(mk(2'b00, 0, 0, 2,      2'b10, 2'b00, 2'b01, 0, 0, 0));
        segs.push_back(mk(2'b00, 0, 1, 1,      2'b10, 2'b00, 2'b01, 0, 0, 0));
        segs.push_back(mk(2'b00, 0, 1, 1,      2'b00, 2'b11, 2'b00, 0, 0, 0));
        segs.push_back(mk(2'b00, 0, 1, 1,      2'b00, 2'b00, 2'b00, 0, 0, 0));
        segs.push_back(mk(2'b00, 0, 1, 1,      2'b00, 2'b11, 2'b00, 0, 0, 0));
        segs.push_back(mk(2'b00, 0, 1, 1,      2'b00, 2'b00, 2'b00, 0, 0, 0));
        segs.push_back(mk(2'b00, 0, 0, 1,      2'b00, 2'b11, 2'b00, 0, 0, 0));
        segs.push_back(mk(2'b00, 0, 0, L_CLR,  2'b11, 2'b00, 2'b00, 0, 0, 0));
        segs.push_back(mk(2'b00, 0, 0, L_BASE, 2'b10, 2'b00, 2'b01, 0, 0, 0));

        repeat (3) step();
        check("reset_outputs", 32'(outs()), 32'({2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0}));
        Reset_n = 1'b1;

        for (int s = 0; s < segs.size(); s++) begin
            for (int c = 0; c < segs[s].n; c++) begin
                Sensor = segs[s].sensor;
                Walk_Req = segs[s].wr;
                Flash_Mode = segs[s].fm;
                check($sformatf("seg%0d_cyc%0d", s, c), 32'(outs()), 32'(segs[s].exp));
                step();
            end
        end
        Sensor = '0; Walk_Req = 0; Flash_Mode = 0;

        // Request held through walk entry only: absorbed, no second walk
        Reprogram = 1; step(); Reprogram = 0;
        Walk_Req = 1;
        wait_for(0, "hold_walk_seen");
        check("hold_walk_wrr", WalkReg_Reset, 1);
        step(); Walk_Req = 0;
        count_wrr(40, n);
        check("hold_no_rewalk", n, 0);

        // Request still high after entry: a second walk follows
        Walk_Req = 1;
        wait_for(0, "hold2_walk_seen");
        step(); step(); Walk_Req = 0;
        count_wrr(25, n);
        check("hold2_rewalk", n, 1);

        // Reprogram during Y1 with a pending walk
        wait_for(1, "reach_g1");
        Walk_Req = 1; step(); Walk_Req = 0;
        wait_for(2, "reach_y1");
        Reprogram = 1; step(); Reprogram = 0;
        check("reprog_outputs", 32'(outs()), 32'({2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0}));
        count_wrr(40, n);
        check("reprog_clears_pending", n, 0);

        // Asynchronous reset in the middle of a walk interval
        Walk_Req = 1; step(); Walk_Req = 0;
        wait_for(0, "reach_walk");
        step();
        #2 Reset_n = 0;
        #1 check("async_reset_walk", 32'({Red, Walk, WalkReg_Reset}), 32'({2'b11, 1'b0, 1'b0}));
        step(); Reset_n = 1;
        check("post_reset_init", 32'(outs()), 32'({2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0}));
        step();
        check("post_reset_g0", 32'(outs()), 32'({2'b10, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0}));

        // Randomised run against the reference model
        Reset_n = 0; step(); Reset_n = 1;
        model_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            exp = model_out();
            check($sformatf("rand_cyc%0d", cyc), 32'(outs()), 32'(exp));
            Tick = ($urandom_range(0, 3) != 0);
            Sensor = 2'($urandom_range(0, 3));
            Walk_Req = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 79) == 0) Flash_Mode = !Flash_Mode;
            Reprogram = ($urandom_range(0, 199) == 0);
            model_step(Tick, Sensor, Walk_Req, Flash_Mode, Reprogram);
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
